vram_arbiter: RTL and testbench

Single-port video-RAM arbiter between the VGA scanout fetch and the CPU load/store path. Each cycle it grants at most one requester and drives one registered RAM command. It returns read data to the owner with a fixed 2-cycle latency. It sits between the CPU core, the VGA timing/pixel pipeline and the on-chip framebuffer RAM (1-cycle synchronous read).

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_sat_counter.sv | 29 ++
 rtl/vram_arbiter.sv | 124 ++++++++++++
 tb/tb_vram_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and types for the video-RAM arbiter slice.
// Owner tags identify which requester a returning read belongs to.
package vram_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int STALL_W    = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage

// File: rtl/vram_sat_counter.sv
// Parameterised up-counter that sticks at all-ones; clear and reset both return it to zero.
module vram_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count register: reset and clear dominate, increment stops at the all-ones value
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between VGA scanout and CPU load/store, 2-cycle read return.
// Optional CPU fairness slot is built in when VRAM_ARB_FAIR_EN is defined.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CPU_SLOT_N = 8
) (
    input  logic               CLK1_50,
    input  logic               RST,
    input  logic               vga_req,
    input  logic [ADDR_W-1:0]  vga_addr,
    output logic               vga_gnt,
    output logic               vga_rvalid,
    output logic [DATA_W-1:0]  vga_rdata,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic               cpu_rvalid,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [STALL_W-1:0] cpu_stall_cnt
);

    logic              force_cpu_s;
    logic              vga_xfer_s;
    logic              cpu_xfer_s;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    owner_t            tag1_r;
    owner_t            tag2_r;

    // Grant selection: VGA first unless a forced CPU slot is due; nothing granted in reset
    always_comb begin
        vga_gnt = 1'b0;
        cpu_ack = 1'b0;
        if (RST) begin
            vga_gnt = 1'b0;
            cpu_ack = 1'b0;
        end else if (force_cpu_s) begin
            vga_gnt = 1'b0;
            cpu_ack = cpu_req;
        end else begin
            vga_gnt = 1'b1;
            cpu_ack = cpu_req & ~vga_req;
        end
    end

    assign vga_xfer_s = vga_req & vga_gnt;
    assign cpu_xfer_s = cpu_req & cpu_ack;

`ifdef VRAM_ARB_FAIR_EN
    localparam int FAIR_W = $clog2(CPU_SLOT_N + 1);
    logic [FAIR_W-1:0] fair_cnt_s;

    // Counts VGA wins while the CPU waits; a CPU win or an idle CPU restarts it
    vram_sat_counter #(.W(FAIR_W)) u_fair_cnt (
        .clk (CLK1_50),
        .rst (RST),
        .clr (cpu_xfer_s | ~cpu_req),
        .inc (vga_xfer_s & cpu_req),
        .cnt (fair_cnt_s)
    );

    assign force_cpu_s = (fair_cnt_s == FAIR_W'(CPU_SLOT_N));
`else
    assign force_cpu_s = 1'b0;
`endif

    // RAM command register and owner tag pipeline; address/data hold on idle cycles
    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            tag1_r      <= OWN_NONE;
            tag2_r      <= OWN_NONE;
        end else begin
            mem_en_r <= vga_xfer_s | cpu_xfer_s;
            tag2_r   <= tag1_r;
            if (vga_xfer_s) begin
                mem_we_r   <= 1'b0;
                mem_addr_r <= vga_addr;
                tag1_r     <= OWN_VGA;
            end else if (cpu_xfer_s) begin
                mem_we_r    <= cpu_we;
                mem_addr_r  <= cpu_addr;
                mem_wdata_r <= cpu_wdata;
                tag1_r      <= cpu_we ? OWN_NONE : OWN_CPU;
            end else begin
                mem_we_r <= 1'b0;
                tag1_r   <= OWN_NONE;
            end
        end
    end

    vram_sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk (CLK1_50),
        .rst (RST),
        .clr (1'b0),
        .inc (cpu_req & ~cpu_ack),
        .cnt (cpu_stall_cnt)
    );

    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign vga_rvalid = (tag2_r == OWN_VGA);
    assign cpu_rvalid = (tag2_r == OWN_CPU);
    assign vga_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle synchronous RAM.
// Fairness checks run only when VRAM_ARB_FAIR_EN is defined; contention/saturation only without it.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [15:0] vga_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] cpu_stall_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0] ram [0:65535];

    vram_arbiter dut (
        .CLK1_50       (clk),
        .RST           (rst),
        .vga_req       (vga_req),
        .vga_addr      (vga_addr),
        .vga_gnt       (vga_gnt),
        .vga_rvalid    (vga_rvalid),
        .vga_rdata     (vga_rdata),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .cpu_stall_cnt (cpu_stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural framebuffer RAM: one command per cycle, read data one cycle later
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ram[16'h0100 + i] = 16'hA000 + 16'(i);
        end
        mem_rdata = 16'h0000;
        rst = 1'b1;
        vga_req = 1'b0; vga_addr = 16'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        repeat (2) next_cycle();

        // Reset state
        @(negedge clk);
        check_vec("rst_mem_en", mem_en, 1'b0);
        check_vec("rst_mem_we", mem_we, 1'b0);
        check_vec("rst_mem_addr", mem_addr, 16'h0000);
        check_vec("rst_mem_wdata", mem_wdata, 16'h0000);
        check_vec("rst_rvalids", {vga_rvalid, cpu_rvalid}, 2'b00);
        check_vec("rst_stall", cpu_stall_cnt, 16'h0000);
        check_vec("rst_grants", {vga_gnt, cpu_ack}, 2'b00);
        next_cycle();
        rst = 1'b0;

        // CPU write then read-back of the same address
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        check_vec("wr_ack", cpu_ack, 1'b1);
        next_cycle();
        cpu_we = 1'b0; cpu_wdata = 16'h0000;
        @(negedge clk);
        check_vec("wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0010, 16'hBEEF});
        check_vec("rd_ack", cpu_ack, 1'b1);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_vec("rd_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0010});
        check_vec("rd_early_rvalid", cpu_rvalid, 1'b0);
        next_cycle();
        @(negedge clk);
        check_vec("rd_rvalid", {cpu_rvalid, vga_rvalid}, 2'b10);
        check_vec("rd_data", cpu_rdata, 16'hBEEF);
        next_cycle();
        @(negedge clk);
        check_vec("rd_rvalid_drop", cpu_rvalid, 1'b0);

        // VGA stream of four consecutive reads
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            vga_req  = (i < 4);
            vga_addr = (i < 4) ? 16'h0100 + 16'(i) : 16'h0000;
            @(negedge clk);
            if (i < 4) check_vec($sformatf("vga_gnt_%0d", i), vga_gnt, 1'b1);
            if (i >= 2 && i < 6) begin
                check_vec($sformatf("vga_rvalid_%0d", i), {vga_rvalid, cpu_rvalid}, 2'b10);
                check_vec($sformatf("vga_rdata_%0d", i), vga_rdata, 16'hA000 + 16'(i - 2));
            end else begin
                check_vec($sformatf("vga_idle_%0d", i), vga_rvalid, 1'b0);
            end
        end

`ifndef VRAM_ARB_FAIR_EN
        // Contention: VGA wins for three cycles, CPU served once VGA drops
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            vga_req = 1'b1; vga_addr = 16'h0100;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
            @(negedge clk);
            check_vec($sformatf("cont_ack_%0d", i), {vga_gnt, cpu_ack}, 2'b10);
        end
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        check_vec("cont_cpu_win", cpu_ack, 1'b1);
        check_vec("cont_stall", cpu_stall_cnt, 16'd3);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_vec("cont_stall_hold", cpu_stall_cnt, 16'd3);
`else
        // Fairness: eight VGA grants, one forced CPU slot, then VGA again
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            vga_req = 1'b1; vga_addr = 16'h0100;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
            @(negedge clk);
            check_vec($sformatf("fair_%0d", i), {vga_gnt, cpu_ack}, (i == 8) ? 2'b01 : 2'b10);
        end
        next_cycle();
        vga_req = 1'b0; cpu_req = 1'b0;
`endif

        // Reset in the cycle after a CPU read is accepted
        repeat (3) next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk);
        check_vec("rr_ack", cpu_ack, 1'b1);
        next_cycle();
        cpu_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_vec("rr_t1", {cpu_rvalid, vga_gnt, cpu_ack}, 3'b000);
        next_cycle();
        @(negedge clk);
        check_vec("rr_t2_rvalid", cpu_rvalid, 1'b0);
        check_vec("rr_t2_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 34'h0);
        check_vec("rr_t2_stall", cpu_stall_cnt, 16'h0000);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_vec("rr_t3_rvalid", cpu_rvalid, 1'b0);

`ifndef VRAM_ARB_FAIR_EN
        // Saturation of the stall counter under continuous contention
        next_cycle();
        vga_req = 1'b1; vga_addr = 16'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check_vec("sat_fffe", cpu_stall_cnt, 16'hFFFE);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_vec("sat_ffff", cpu_stall_cnt, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        check_vec("sat_hold", cpu_stall_cnt, 16'hFFFF);
        vga_req = 1'b0; cpu_req = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
